phase_sequencer: RTL and testbench

- Parametrised successor to the fixed three-stage irrigation/ventilation controller.
- Steps through NUM_PHASES programmable phases. Each phase has its own duration and its own actuator output mask.
- Adds pause/hold, repeat/continuous looping, a phase index and a completed-pass count.
- Sits between the greenhouse control registers and the actuator drivers.

---
 rtl/phase_sequencer.sv | 168 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Programmable multi-phase actuator sequencer. Steps through NUM_PHASES
// phases, each with its own latched duration and output mask, with pause,
// abort, repeat/continuous looping and a saturating completed-pass count.
module phase_sequencer #(
  parameter int NUM_PHASES  = 4,
  parameter int NUM_OUTPUTS = 3,
  parameter int DUR_WIDTH   = 8,
  parameter int RPT_WIDTH   = 4,
  parameter int IDX_WIDTH   = $clog2(NUM_PHASES)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              pause,
  input  logic [RPT_WIDTH-1:0]              repeat_count,
  input  logic [NUM_PHASES*DUR_WIDTH-1:0]   phase_duration,
  input  logic [NUM_PHASES*NUM_OUTPUTS-1:0] phase_mask,
  output logic [NUM_OUTPUTS-1:0]            actuators,
  output logic [IDX_WIDTH-1:0]              phase_idx,
  output logic                              busy,
  output logic                              paused,
  output logic                              done,
  output logic [RPT_WIDTH-1:0]              pass_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PHASES - 1);

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DUR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DUR_WIDTH-1:0]   dur_q, dur_d;
  logic [NUM_OUTPUTS-1:0] mask_q, mask_d;
  logic [RPT_WIDTH-1:0]   rpt_q, rpt_d;
  logic [RPT_WIDTH-1:0]   pass_q, pass_d;

  logic [IDX_WIDTH-1:0]   sel_idx;
  logic [DUR_WIDTH-1:0]   sel_dur;
  logic [DUR_WIDTH-1:0]   sel_eff;
  logic [NUM_OUTPUTS-1:0] sel_mask;
  logic                   last_cycle;
  logic [RPT_WIDTH:0]     pass_ext;
  logic [RPT_WIDTH-1:0]   pass_sat;
  logic                   keep_looping;

  // Phase whose settings are loaded on the next phase entry: the successor
  // while running, otherwise phase 0 (start of a pass).
  always_comb begin
    sel_idx  = '0;
    if (state_q == S_RUN && idx_q != LAST_IDX)
      sel_idx = idx_q + IDX_WIDTH'(1);
    sel_dur  = '0;
    sel_mask = '0;
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      if (sel_idx == IDX_WIDTH'(p)) begin
        sel_dur  = phase_duration[p*DUR_WIDTH +: DUR_WIDTH];
        sel_mask = phase_mask[p*NUM_OUTPUTS +: NUM_OUTPUTS];
      end
    end
  end

  // Zero duration is stored as one cycle so the last-cycle test is uniform.
  assign sel_eff      = (sel_dur == '0) ? DUR_WIDTH'(1) : sel_dur;
  assign last_cycle   = (cnt_q == dur_q - DUR_WIDTH'(1));
  assign pass_ext     = {1'b0, pass_q} + (RPT_WIDTH+1)'(1);
  assign pass_sat     = (pass_q == '1) ? pass_q : pass_ext[RPT_WIDTH-1:0];
  assign keep_looping = (rpt_q == '0) || (pass_ext < {1'b0, rpt_q});

  // Next-state and datapath update; abort outranks pause, pause outranks advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    mask_d  = mask_q;
    rpt_d   = rpt_q;
    pass_d  = pass_q;
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = '0;
          dur_d   = sel_eff;
          mask_d  = sel_mask;
          rpt_d   = repeat_count;
          pass_d  = '0;
        end
        S_RUN: begin
          if (pause) begin
            // The cycle in which pause is seen still counts as a RUN cycle,
            // except the last one, which is re-run after resuming so the
            // advance only ever happens from RUN.
            state_d = S_PAUSED;
            if (!last_cycle)
              cnt_d = cnt_q + DUR_WIDTH'(1);
          end else if (last_cycle) begin
            cnt_d = '0;
            if (idx_q != LAST_IDX) begin
              idx_d  = sel_idx;
              dur_d  = sel_eff;
              mask_d = sel_mask;
            end else begin
              pass_d = pass_sat;
              if (keep_looping) begin
                idx_d  = '0;
                dur_d  = sel_eff;
                mask_d = sel_mask;
              end else begin
                state_d = S_END;
              end
            end
          end else begin
            cnt_d = cnt_q + DUR_WIDTH'(1);
          end
        end
        S_PAUSED: begin
          if (!pause)
            state_d = S_RUN;
        end
        S_END: begin
          state_d = S_END;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dur_q   <= '0;
      mask_q  <= '0;
      rpt_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      mask_q  <= mask_d;
      rpt_q   <= rpt_d;
      pass_q  <= pass_d;
    end
  end

  assign actuators  = (state_q == S_RUN) ? mask_q : '0;
  assign phase_idx  = idx_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_PAUSED);
  assign paused     = (state_q == S_PAUSED);
  assign done       = (state_q == S_END);
  assign pass_count = pass_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed scoreboard bench for phase_sequencer (default parameters).
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  repeat_count = '0;
  logic [31:0] phase_duration = '0;
  logic [11:0] phase_mask = '0;
  logic [2:0]  actuators;
  logic [1:0]  phase_idx;
  logic        busy;
  logic        paused;
  logic        done;
  logic [3:0]  pass_count;

  int compared = 0;
  int mismatched = 0;
  logic [11:0] sb[$];
  logic [2:0]  mk[4];

  phase_sequencer #(
    .NUM_PHASES(4),
    .NUM_OUTPUTS(3),
    .DUR_WIDTH(8),
    .RPT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .pause(pause),
    .repeat_count(repeat_count),
    .phase_duration(phase_duration),
    .phase_mask(phase_mask),
    .actuators(actuators),
    .phase_idx(phase_idx),
    .busy(busy),
    .paused(paused),
    .done(done),
    .pass_count(pass_count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic push(input logic [2:0] a, input logic [1:0] i, input logic b,
                      input logic p, input logic d, input logic [3:0] pc);
    sb.push_back({a, i, b, p, d, pc});
  endtask

  task automatic compare(input string tag);
    logic [11:0] exp_v;
    logic [11:0] got_v;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
      return;
    end
    exp_v = sb.pop_front();
    got_v = {actuators, phase_idx, busy, paused, done, pass_count};
    assert (got_v === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b (act,idx,busy,paused,done,pass)",
             tag, got_v, exp_v);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] a, input logic [1:0] i,
                     input logic b, input logic p, input logic d,
                     input logic [3:0] pc, input int n);
    for (int k = 0; k < n; k++) begin
      push(a, i, b, p, d, pc);
      @(posedge clk);
      #1;
      compare(tag);
    end
  endtask

  task automatic set_cfg(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3,
                         input logic [3:0] r);
    phase_duration = {d3, d2, d1, d0};
    phase_mask     = {mk[3], mk[2], mk[1], mk[0]};
    repeat_count   = r;
  endtask

  initial begin
    // Reset state
    #3;
    push(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    compare("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run("idle", 3'b000, 2'd0, 0, 0, 0, 4'd0, 1);

    // Basic pass: durations 2,3,1,4; masks 001,000,100,010; R=1
    mk = '{3'b001, 3'b000, 3'b100, 3'b010};
    set_cfg(8'd2, 8'd3, 8'd1, 8'd4, 4'd1);
    enable = 1'b1;
    run("basic_p0", 3'b001, 2'd0, 1, 0, 0, 4'd0, 2);
    run("basic_p1", 3'b000, 2'd1, 1, 0, 0, 4'd0, 3);
    run("basic_p2", 3'b100, 2'd2, 1, 0, 0, 4'd0, 1);
    run("basic_p3", 3'b010, 2'd3, 1, 0, 0, 4'd0, 4);
    run("basic_end", 3'b000, 2'd3, 0, 0, 1, 4'd1, 2);
    enable = 1'b0;
    run("basic_idle", 3'b000, 2'd0, 0, 0, 0, 4'd1, 1);

    // Zero duration: 0,2,0,1 -> 1,2,1,1 cycles
    mk = '{3'b001, 3'b010, 3'b100, 3'b111};
    set_cfg(8'd0, 8'd2, 8'd0, 8'd1, 4'd1);
    enable = 1'b1;
    run("zero_p0", 3'b001, 2'd0, 1, 0, 0, 4'd0, 1);
    run("zero_p1", 3'b010, 2'd1, 1, 0, 0, 4'd0, 2);
    run("zero_p2", 3'b100, 2'd2, 1, 0, 0, 4'd0, 1);
    run("zero_p3", 3'b111, 2'd3, 1, 0, 0, 4'd0, 1);
    run("zero_end", 3'b000, 2'd3, 0, 0, 1, 4'd1, 1);
    enable = 1'b0;
    run("zero_idle", 3'b000, 2'd0, 0, 0, 0, 4'd1, 1);

    // Pause 3 cycles during cycle 2 of a 4-cycle phase
    mk = '{3'b011, 3'b001, 3'b010, 3'b100};
    set_cfg(8'd4, 8'd1, 8'd1, 8'd1, 4'd1);
    enable = 1'b1;
    run("pause_pre", 3'b011, 2'd0, 1, 0, 0, 4'd0, 2);
    pause = 1'b1;
    run("pause_hold", 3'b000, 2'd0, 1, 1, 0, 4'd0, 3);
    pause = 1'b0;
    run("pause_rest", 3'b011, 2'd0, 1, 0, 0, 4'd0, 2);
    run("pause_p1", 3'b001, 2'd1, 1, 0, 0, 4'd0, 1);
    run("pause_p2", 3'b010, 2'd2, 1, 0, 0, 4'd0, 1);
    run("pause_p3", 3'b100, 2'd3, 1, 0, 0, 4'd0, 1);
    run("pause_end", 3'b000, 2'd3, 0, 0, 1, 4'd1, 1);
    enable = 1'b0;
    run("pause_idle", 3'b000, 2'd0, 0, 0, 0, 4'd1, 1);

    // Pause on a phase's last cycle beats the advance
    mk = '{3'b001, 3'b010, 3'b100, 3'b111};
    set_cfg(8'd1, 8'd1, 8'd1, 8'd1, 4'd1);
    enable = 1'b1;
    run("plast_p0", 3'b001, 2'd0, 1, 0, 0, 4'd0, 1);
    pause = 1'b1;
    run("plast_hold", 3'b000, 2'd0, 1, 1, 0, 4'd0, 1);
    pause = 1'b0;
    run("plast_p0b", 3'b001, 2'd0, 1, 0, 0, 4'd0, 1);
    run("plast_p1", 3'b010, 2'd1, 1, 0, 0, 4'd0, 1);
    enable = 1'b0;
    run("plast_idle", 3'b000, 2'd0, 0, 0, 0, 4'd0, 1);

    // Repeat R=2, all durations 1
    set_cfg(8'd1, 8'd1, 8'd1, 8'd1, 4'd2);
    enable = 1'b1;
    for (int ps = 0; ps < 2; ps++)
      for (int ph = 0; ph < 4; ph++)
        run("rep_run", mk[ph], 2'(ph), 1, 0, 0, 4'(ps), 1);
    run("rep_end", 3'b000, 2'd3, 0, 0, 1, 4'd2, 1);
    enable = 1'b0;
    run("rep_idle", 3'b000, 2'd0, 0, 0, 0, 4'd2, 1);

    // Continuous R=0: pass_count saturates at 15
    repeat_count = 4'd0;
    enable = 1'b1;
    for (int ps = 0; ps < 17; ps++)
      for (int ph = 0; ph < 4; ph++)
        run("cont_run", mk[ph], 2'(ph), 1, 0, 0, (ps > 15) ? 4'd15 : 4'(ps), 1);
    enable = 1'b0;
    run("cont_idle", 3'b000, 2'd0, 0, 0, 0, 4'd15, 1);

    // Abort mid phase 2 of second pass, then restart
    set_cfg(8'd1, 8'd1, 8'd3, 8'd1, 4'd0);
    enable = 1'b1;
    run("abort_a0", 3'b001, 2'd0, 1, 0, 0, 4'd0, 1);
    run("abort_a1", 3'b010, 2'd1, 1, 0, 0, 4'd0, 1);
    run("abort_a2", 3'b100, 2'd2, 1, 0, 0, 4'd0, 3);
    run("abort_a3", 3'b111, 2'd3, 1, 0, 0, 4'd0, 1);
    run("abort_b0", 3'b001, 2'd0, 1, 0, 0, 4'd1, 1);
    run("abort_b1", 3'b010, 2'd1, 1, 0, 0, 4'd1, 1);
    run("abort_b2", 3'b100, 2'd2, 1, 0, 0, 4'd1, 1);
    enable = 1'b0;
    run("abort_idle", 3'b000, 2'd0, 0, 0, 0, 4'd1, 1);
    enable = 1'b1;
    run("abort_restart", 3'b001, 2'd0, 1, 0, 0, 4'd0, 1);
    enable = 1'b0;
    run("abort_idle2", 3'b000, 2'd0, 0, 0, 0, 4'd0, 1);

    // Live inputs: change phase 0 settings while it runs
    set_cfg(8'd3, 8'd1, 8'd1, 8'd1, 4'd1);
    enable = 1'b1;
    run("live_p0", 3'b001, 2'd0, 1, 0, 0, 4'd0, 1);
    phase_duration[7:0] = 8'd10;
    phase_mask[2:0] = 3'b110;
    run("live_p0_rest", 3'b001, 2'd0, 1, 0, 0, 4'd0, 2);
    run("live_p1", 3'b010, 2'd1, 1, 0, 0, 4'd0, 1);
    run("live_p2", 3'b100, 2'd2, 1, 0, 0, 4'd0, 1);
    run("live_p3", 3'b111, 2'd3, 1, 0, 0, 4'd0, 1);
    run("live_end", 3'b000, 2'd3, 0, 0, 1, 4'd1, 1);
    enable = 1'b0;
    run("live_idle", 3'b000, 2'd0, 0, 0, 0, 4'd1, 1);
    enable = 1'b1;
    run("live_new_p0", 3'b110, 2'd0, 1, 0, 0, 4'd0, 10);
    run("live_new_p1", 3'b010, 2'd1, 1, 0, 0, 4'd0, 1);

    // Asynchronous reset mid-RUN, checked between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    push(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    compare("async_reset");
    enable = 1'b0;
    #2;
    reset_n = 1'b1;
    run("post_reset", 3'b000, 2'd0, 0, 0, 0, 4'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
